// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use and multicycle stalls, branch flushes, stall counter
//   clk, rst_n           : clock, synchronous active-low reset
//   i_id_rs/i_id_src_used: ID source indices and read flags (load-use detection)
//   i_ex_*               : EX source indices, destination, load/multicycle/write flags
//   i_branch_taken       : branch/jump resolved taken in EX
//   i_mem_*/i_wb_*       : MEM and WB destination and write enables (forwarding sources)
//   o_fwd_sel            : per-operand select, 00 regfile, 10 MEM, 01 WB
//   o_stall_*/o_flush_*  : pipeline register holds and bubbles
//   o_mc_busy            : multicycle op still occupying EX
//   o_stall_cycles       : saturating count of cycles with o_stall_id high
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int N_SRC  = 2,
  parameter int MC_LAT = 3,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC*REG_AW-1:0] i_id_rs,
  input  logic [N_SRC-1:0]        i_id_src_used,
  input  logic [N_SRC*REG_AW-1:0] i_ex_rs,
  input  logic                    i_ex_valid,
  input  logic [REG_AW-1:0]       i_ex_rd,
  input  logic                    i_ex_reg_write,
  input  logic                    i_ex_mem_read,
  input  logic                    i_ex_multi,
  input  logic                    i_branch_taken,
  input  logic [REG_AW-1:0]       i_mem_rd,
  input  logic                    i_mem_reg_write,
  input  logic [REG_AW-1:0]       i_wb_rd,
  input  logic                    i_wb_reg_write,
  output logic [N_SRC*2-1:0]      o_fwd_sel,
  output logic                    o_stall_if,
  output logic                    o_stall_id,
  output logic                    o_stall_ex,
  output logic                    o_flush_id,
  output logic                    o_flush_ex,
  output logic                    o_flush_mem,
  output logic                    o_mc_busy,
  output logic [CNT_W-1:0]        o_stall_cycles
);
  localparam int MC_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           r_state, w_state_nxt;
  logic [MC_W-1:0]  r_mc_cnt, w_mc_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [N_SRC-1:0] w_lu_src;
  logic             w_lu, w_mc_start, w_mc_stall, w_br, w_lu_eff;
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    logic [REG_AW-1:0] w_ex_rs, w_id_rs;
    logic              w_mem_hit, w_wb_hit;
    assign w_ex_rs   = i_ex_rs[g*REG_AW +: REG_AW];
    assign w_id_rs   = i_id_rs[g*REG_AW +: REG_AW];
    assign w_mem_hit = i_mem_reg_write & (|w_ex_rs) & (w_ex_rs == i_mem_rd);
    assign w_wb_hit  = i_wb_reg_write & (|w_ex_rs) & (w_ex_rs == i_wb_rd);
    assign w_lu_src[g] = i_id_src_used[g] & (w_id_rs == i_ex_rd);
    assign o_fwd_sel[2*g +: 2] = !rst_n ? 2'b00 : w_mem_hit ? 2'b10 : w_wb_hit ? 2'b01 : 2'b00;
  end
  assign w_lu       = i_ex_valid & i_ex_mem_read & i_ex_reg_write & (|i_ex_rd) & (|w_lu_src);
  assign w_mc_start = (r_state == IDLE) & i_ex_valid & i_ex_multi & (MC_LAT > 1);
  // the start cycle itself stalls, so BUSY only stalls while cycles remain after it
  assign w_mc_stall = w_mc_start | ((r_state == BUSY) & (r_mc_cnt != '0));
  assign w_br       = i_branch_taken & i_ex_valid & ~w_mc_stall;
  assign w_lu_eff   = w_lu & ~w_mc_stall & ~w_br;
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    if (w_mc_start) begin
      w_state_nxt  = BUSY;
      w_mc_cnt_nxt = MC_W'(MC_LAT - 2);
    end else if (r_state == BUSY) begin
      if (r_mc_cnt != '0) w_mc_cnt_nxt = r_mc_cnt - 1'b1;
      else w_state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_mc_cnt       <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (o_stall_id && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end
  assign o_stall_if     = rst_n & (w_mc_stall | w_lu_eff);
  assign o_stall_id     = rst_n & (w_mc_stall | w_lu_eff);
  assign o_stall_ex     = rst_n & w_mc_stall;
  assign o_flush_mem    = rst_n & w_mc_stall;
  assign o_flush_id     = rst_n & w_br;
  assign o_flush_ex     = rst_n & (w_br | w_lu_eff);
  assign o_mc_busy      = rst_n & (r_state == BUSY);
  assign o_stall_cycles = r_stall_cycles;
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Next-generation forwarding and hazard block for the pipelined RISC-V core.
- Generalises MEM/WB operand forwarding to N_SRC source operands and a parametrised register-address width.
- Adds load-use stall detection, taken-branch flush generation, a multicycle-EX stall FSM and a saturating stall-cycle performance counter.
- Sits beside the ID/EX pipeline registers. Drives ALU operand muxes and pipeline-register enables/flushes.

Parameters:
- REG_AW, 5, register address width.
- N_SRC, 2, number of source operands per instruction.
- MC_LAT, 3, EX occupancy in cycles of a multicycle op (>=1).
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- id_rs  in  N_SRC*REG_AW  ID-stage source register indices; operand i is at [i*REG_AW +: REG_AW].
- id_src_used  in  N_SRC  per-operand "source actually read" flags.
- ex_rs  in  N_SRC*REG_AW  EX-stage source register indices.
- ex_valid  in  1  EX holds a valid instruction.
- ex_rd  in  REG_AW  EX destination register.
- ex_reg_write  in  1  EX writes rd.
- ex_mem_read  in  1  EX instruction is a load.
- ex_multi  in  1  EX instruction is multicycle.
- branch_taken  in  1  branch/jump resolved taken in EX.
- mem_rd  in  REG_AW  MEM destination register.
- mem_reg_write  in  1  MEM writes rd.
- wb_rd  in  REG_AW  WB destination register.
- wb_reg_write  in  1  WB writes rd.
- fwd_sel  out  N_SRC*2  per-operand forward select: 00 regfile, 10 MEM, 01 WB.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID.
- stall_ex  out  1  hold ID/EX.
- flush_id  out  1  bubble IF/ID.
- flush_ex  out  1  bubble ID/EX.
- flush_mem  out  1  bubble EX/MEM.
- mc_busy  out  1  FSM in BUSY.
- stall_cycles  out  CNT_W  count of cycles with stall_id=1.

Behaviour:
- Reset: rst_n sampled low at a clk edge -> state=IDLE, mc_cnt=0, stall_cycles=0.
  - While rst_n=0, all stall/flush outputs, mc_busy and fwd_sel are forced to 0.
  - Reset mid-BUSY aborts the op. There is no residual stall after rst_n rises.
- Forwarding (combinational, zero latency), per operand i:
  - MEM match = ex_rs[i]==mem_rd & mem_reg_write & ex_rs[i]!=0.
  - WB match = same test against wb_rd / wb_reg_write.
  - MEM has priority over WB. No match -> 00.
- Load-use (combinational):
  - lu = ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & OR over i of (id_src_used[i] & id_rs[i]==ex_rd).
  - lu -> stall_if=1, stall_id=1, flush_ex=1 for one cycle. The dependent operand later forwards from WB.
- Multicycle FSM, states IDLE and BUSY:
  - mc_start = IDLE & ex_valid & ex_multi & MC_LAT>1.
  - On mc_start: next state=BUSY, mc_cnt<=MC_LAT-2.
  - In BUSY: if mc_cnt!=0, decrement; if mc_cnt==0, next state=IDLE.
  - mc_stall = mc_start | (BUSY & mc_cnt!=0).
  - Net effect: stalls asserted for exactly MC_LAT-1 consecutive cycles; op occupies EX for MC_LAT cycles.
  - mc_stall -> stall_if, stall_id, stall_ex, flush_mem = 1.
  - mc_busy = (state==BUSY).
  - MC_LAT==1 -> FSM never leaves IDLE and no stalls are generated.
- Branch: branch_taken & ex_valid -> flush_id=1, flush_ex=1.
- Priority (highest first): reset > mc_stall > branch > load-use.
  - mc_stall active: branch_taken and lu are ignored, and flush_id/flush_ex are 0.
  - branch with lu in the same cycle: flush only, stall_if/stall_id=0.
- stall_cycles: increments by 1 each cycle stall_id=1, saturates at all-ones (no wrap).
- Widths: all index compares are exactly REG_AW bits. Register 0 never forwards or triggers lu.

Test Plan:
- Forward priority: ex_rs0=5, mem_rd=5, wb_rd=5, both writes=1 -> fwd_sel[1:0]=10. Set mem_reg_write=0 -> 01. Set ex_rs0=0 -> 00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs1=7, id_src_used[1]=1 -> one cycle of stall_if=stall_id=flush_ex=1; stall_cycles 0->1. Clear id_src_used[1] -> no stall.
- Multicycle MC_LAT=4: ex_multi=1 at cycle 0 -> stall_ex=flush_mem=1 on cycles 0-2, 0 on cycle 3. mc_busy=1 on cycles 1-3. stall_cycles=3.
- Branch vs load-use: branch_taken=1 with lu true -> flush_id=flush_ex=1, stall_if=0. Branch during BUSY -> no flush.
- Reset mid-BUSY: rst_n=0 on cycle 1 of a MC_LAT=4 op -> next edge state IDLE, outputs 0, stall_cycles=0. After release there are no stalls.
- Saturation with CNT_W=4: hold lu for 20 cycles -> stall_cycles stops at 15.
